axis_pkt_fifo_sc: RTL and testbench

AXIS_PKT_FIFO_SC -- requirements
Module: axis_pkt_fifo_sc

---
 rtl/axis_pkt_fifo_sc.sv | 178 +++++++++++++++++
 tb/tb_axis_pkt_fifo_sc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo_sc.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo_sc
//   Single-clock AXI-Stream store-and-forward packet FIFO. A packet becomes
//   visible on the master side only after its last beat has been written and
//   committed. Packets flagged bad (tuser on the tlast beat) are rewound and
//   dropped. Packets longer than DEPTH are dropped once no committed data is
//   left ahead of them.
//
//   Optional feature macro: AXIS_PKT_FIFO_STATS_EN
//     defined   -> stat_pkt_cnt / stat_drop_cnt count committed / dropped packets
//     undefined -> both statistics ports are tied to zero
//
// Ports
//   s_axis_aclk, s_axis_aresetn    clock, async active-low reset
//   s_axis_t{valid,ready,data,keep,last,user}   slave stream (tuser = bad packet)
//   m_axis_t{valid,ready,data,keep,last}        master stream
//   pkt_avail                      committed packets not yet fully read
//   stat_pkt_cnt, stat_drop_cnt    packet statistics (wrap on overflow)
// -----------------------------------------------------------------------------
module axis_pkt_fifo_sc #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 128,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      s_axis_aclk,
    input  logic                      s_axis_aresetn,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [$clog2(DEPTH):0]    pkt_avail,
    output logic [CNT_WIDTH-1:0]      stat_pkt_cnt,
    output logic [CNT_WIDTH-1:0]      stat_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  last;
        logic [KW-1:0]         keep;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {IDLE, WRITE, DROP} wstate_e;

    wstate_e       state_q;
    logic [PW-1:0] wr_ptr_q, wr_commit_q;
    // rd_ptr_q frees storage on the master handshake; rd_nxt_q is the fetch
    // pointer feeding the output stage (at most one beat ahead of rd_ptr_q).
    logic [PW-1:0] rd_ptr_q, rd_nxt_q;
    logic [PW-1:0] pkt_avail_q;
    logic          rdy_en_q;
    beat_t         mem_q [DEPTH];
    beat_t         out_q;
    logic          out_vld_q;

    logic full, oversize, dropping, s_acc, store, commit, load, m_hs;
    beat_t in_beat;

    assign in_beat  = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};
    // The beat sitting in the output stage still occupies its slot.
    assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    // Nothing committed is left to drain, yet the open packet fills storage:
    // it can never fit, so discard it instead of stalling forever.
    assign oversize = (state_q == WRITE) && full && (wr_commit_q == rd_ptr_q);
    assign dropping = (state_q == DROP) || oversize;

    assign s_axis_tready = rdy_en_q && (dropping || !full);
    assign s_acc         = s_axis_tvalid && s_axis_tready;
    assign store         = s_acc && !dropping && !(s_axis_tlast && s_axis_tuser);
    assign commit        = s_acc && !dropping && s_axis_tlast && !s_axis_tuser;

    assign m_hs = out_vld_q && m_axis_tready;
    assign load = (rd_nxt_q != wr_commit_q) && (!out_vld_q || m_axis_tready);

    // ---------------- write side ----------------
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (oversize) begin
                wr_ptr_q <= wr_commit_q;
                state_q  <= (s_acc && s_axis_tlast) ? IDLE : DROP;
            end else if (state_q == DROP) begin
                if (s_acc && s_axis_tlast) state_q <= IDLE;
            end else if (s_acc) begin
                if (!s_axis_tlast) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                    state_q  <= WRITE;
                end else if (!s_axis_tuser) begin
                    wr_ptr_q    <= wr_ptr_q + PW'(1);
                    wr_commit_q <= wr_ptr_q + PW'(1);
                    state_q     <= IDLE;
                end else begin
                    wr_ptr_q <= wr_commit_q;
                    state_q  <= IDLE;
                end
            end
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (store) mem_q[wr_ptr_q[AW-1:0]] <= in_beat;
    end

    // ---------------- read side ----------------
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            rd_ptr_q  <= '0;
            rd_nxt_q  <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (m_hs) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (load) begin
                out_q     <= mem_q[rd_nxt_q[AW-1:0]];
                rd_nxt_q  <= rd_nxt_q + PW'(1);
                out_vld_q <= 1'b1;
            end else if (m_hs) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            pkt_avail_q <= '0;
        end else if (commit && !(m_hs && out_q.last)) begin
            pkt_avail_q <= pkt_avail_q + PW'(1);
        end else if (!commit && m_hs && out_q.last) begin
            pkt_avail_q <= pkt_avail_q - PW'(1);
        end
    end

    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tkeep  = out_q.keep;
    assign pkt_avail     = pkt_avail_q;

    // ---------------- statistics ----------------
`ifdef AXIS_PKT_FIFO_STATS_EN
    logic [CNT_WIDTH-1:0] pkt_cnt_q, drop_cnt_q;
    logic                 drop_evt;

    // Bad tlast in a normal packet, or tlast closing a packet being discarded.
    assign drop_evt = s_acc && s_axis_tlast && (dropping || s_axis_tuser);

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (commit)   pkt_cnt_q  <= pkt_cnt_q + CNT_WIDTH'(1);
            if (drop_evt) drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
`else
    assign stat_pkt_cnt  = '0;
    assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_fifo_sc.sv
// Bench for axis_pkt_fifo_sc: a queue-level packet model predicts every output
// each cycle; directed scenarios add hand-computed literal expectations.
module tb_axis_pkt_fifo_sc;
    localparam int DW = 32, DEPTH = 16, CW = 4, KW = DW / 8;
`ifdef AXIS_PKT_FIFO_STATS_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic m_tvalid, m_tready = 1'b1, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [$clog2(DEPTH):0] pkt_avail;
    logic [CW-1:0] stat_pkt, stat_drop;

    always #5 clk = ~clk;

    axis_pkt_fifo_sc #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .pkt_avail(pkt_avail), .stat_pkt_cnt(stat_pkt), .stat_drop_cnt(stat_drop)
    );

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
        int            rdy;   // first cycle the beat may be presented
    } mbeat_t;

    mbeat_t fifo[$];   // committed beats not yet handed out (incl. output stage)
    mbeat_t cur[$];    // beats of the packet currently being written
    bit dropping = 0, rdy_ok = 0;
    int cyc = 0, m_pkt = 0, m_drop = 0;

    function automatic bit model_tready();
        int occ;
        occ = fifo.size() + cur.size();
        // room left, or nothing committed ahead so an overlong packet is discarded
        return rdy_ok && (dropping || occ < DEPTH || fifo.size() == 0);
    endfunction

    function automatic bit model_mvalid();
        return fifo.size() > 0 && fifo[0].rdy <= cyc;
    endfunction

    function automatic int model_avail();
        int n = 0;
        foreach (fifo[i]) if (fifo[i].last) n++;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo.delete(); cur.delete();
            dropping = 0; rdy_ok = 0; m_pkt = 0; m_drop = 0;
        end else begin
            bit tr, mv, over;
            mbeat_t b;
            over = !dropping && cur.size() > 0 && fifo.size() == 0 &&
                   (fifo.size() + cur.size()) >= DEPTH;
            tr = model_tready();
            mv = model_mvalid();
            if (mv && m_tready) void'(fifo.pop_front());
            b.last = s_tlast; b.keep = s_tkeep; b.data = s_tdata; b.rdy = cyc + 2;
            if (s_tvalid && tr) begin
                if (dropping || over) begin
                    cur.delete();
                    if (s_tlast) begin dropping = 0; m_drop++; end
                    else dropping = 1;
                end else begin
                    cur.push_back(b);
                    if (s_tlast && s_tuser) begin
                        cur.delete(); m_drop++;
                    end else if (s_tlast) begin
                        foreach (cur[i]) begin cur[i].rdy = cyc + 2; fifo.push_back(cur[i]); end
                        cur.delete(); m_pkt++;
                    end
                end
            end else if (over) begin
                cur.delete(); dropping = 1;
            end
            rdy_ok = 1;
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    int n_out = 0, rise_cyc = -1, last_hs_cyc = -1, lo_cnt = 0, max_av = 0;
    bit prev_v = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
            chk("rst_s_tready", 64'(s_tready), 64'(0));
            chk("rst_pkt_avail", 64'(pkt_avail), 64'(0));
            chk("rst_stat_pkt", 64'(stat_pkt), 64'(0));
            chk("rst_stat_drop", 64'(stat_drop), 64'(0));
        end else begin
            chk("s_tready", 64'(s_tready), 64'(model_tready()));
            chk("m_tvalid", 64'(m_tvalid), 64'(model_mvalid()));
            if (model_mvalid()) begin
                chk("m_tdata", 64'(m_tdata), 64'(fifo[0].data));
                chk("m_tkeep", 64'(m_tkeep), 64'(fifo[0].keep));
                chk("m_tlast", 64'(m_tlast), 64'(fifo[0].last));
            end
            chk("pkt_avail", 64'(pkt_avail), 64'(model_avail()));
            chk("stat_pkt", 64'(stat_pkt), ST ? 64'(CW'(m_pkt)) : 64'(0));
            chk("stat_drop", 64'(stat_drop), ST ? 64'(CW'(m_drop)) : 64'(0));
            if (!s_tready) lo_cnt++;
            if (m_tvalid && m_tready) begin n_out++; last_hs_cyc = cyc; end
            if (m_tvalid && !prev_v) rise_cyc = cyc;
            if (int'(pkt_avail) > max_av) max_av = int'(pkt_avail);
        end
        prev_v = m_tvalid;
    end

    // ---------------- stimulus ----------------
    // Sends beats [0, nb) of a len-beat packet; tc = cycle the final sent beat was accepted.
    task automatic send(input int len, input bit user, input int tag, input int nb, output int tc);
        tc = -1;
        for (int i = 0; i < nb; i++) begin
            int w = 0;
            bit hs = 0;
            s_tvalid = 1'b1;
            s_tdata  = DW'(tag * 256 + i);
            s_tkeep  = (i == len - 1) ? 4'h7 : 4'hF;
            s_tlast  = (i == len - 1);
            s_tuser  = (i == len - 1) ? user : tag[0];   // ignored on non-last beats
            while (!hs) begin
                @(negedge clk);
                hs = s_tready;
                tc = cyc;
                @(posedge clk); #1;
                if (++w > 500) begin
                    chk("send_timeout", 64'(0), 64'(1));
                    s_tvalid = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    int tc, s0, n0, l0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 4-beat good packet: latency 2 cycles after tlast
        n0 = n_out;
        send(4, 0, 1, 4, tc);
        repeat (8) @(posedge clk); #1;
        chk("t1_beats", 64'(n_out - n0), 64'(4));
        chk("t1_latency", 64'(rise_cyc - tc), 64'(2));
        chk("t1_stat_pkt", 64'(stat_pkt), ST ? 64'(1) : 64'(0));

        // bad 3-beat packet then good 2-beat packet
        n0 = n_out;
        send(3, 1, 2, 3, tc);
        send(2, 0, 3, 2, tc);
        repeat (8) @(posedge clk); #1;
        chk("t2_beats", 64'(n_out - n0), 64'(2));
        chk("t2_stat_pkt", 64'(stat_pkt), ST ? 64'(2) : 64'(0));
        chk("t2_stat_drop", 64'(stat_drop), ST ? 64'(1) : 64'(0));

        // 20-beat packet into 16-deep empty FIFO: dropped without backpressure
        n0 = n_out; l0 = lo_cnt;
        send(20, 0, 4, 20, tc);
        repeat (6) @(posedge clk); #1;
        chk("t3_no_output", 64'(n_out - n0), 64'(0));
        chk("t3_tready_high", 64'(lo_cnt - l0), 64'(0));
        chk("t3_stat_drop", 64'(stat_drop), ST ? 64'(2) : 64'(0));
        send(4, 0, 5, 4, tc);
        repeat (8) @(posedge clk); #1;
        chk("t3_next_pkt", 64'(n_out - n0), 64'(4));

        // two 8-beat packets with output stalled fill storage exactly
        m_tready = 1'b0;
        n0 = n_out;
        send(8, 0, 6, 8, tc);
        send(8, 0, 7, 8, tc);
        @(negedge clk);
        chk("t4_full_tready", 64'(s_tready), 64'(0));
        chk("t4_pkt_avail", 64'(pkt_avail), 64'(2));
        @(posedge clk); #1 m_tready = 1'b1;
        repeat (25) @(posedge clk); #1;
        chk("t4_beats", 64'(n_out - n0), 64'(16));
        chk("t4_pkt_avail_end", 64'(pkt_avail), 64'(0));

        // 1000 back-to-back single-beat packets
        n0 = n_out; max_av = 0;
        send(1, 0, 8, 1, s0);
        for (int k = 1; k < 1000; k++) send(1, 0, 8 + k, 1, tc);
        repeat (6) @(posedge clk); #1;
        chk("t5_in_span", 64'(tc - s0), 64'(999));
        chk("t5_beats", 64'(n_out - n0), 64'(1000));
        chk("t5_last_out", 64'(last_hs_cyc), 64'(tc + 2));
        chk("t5_avail_bound", 64'(max_av <= 3), 64'(1));

        // reset during beat 2 of 5 with a committed packet waiting
        m_tready = 1'b0;
        send(2, 0, 2000, 2, tc);
        send(5, 0, 2001, 2, tc);
        repeat (3) @(posedge clk); #1;
        chk("t6_pre_valid", 64'(m_tvalid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_valid_cleared", 64'(m_tvalid), 64'(0));
        chk("t6_tready_cleared", 64'(s_tready), 64'(0));
        chk("t6_avail_cleared", 64'(pkt_avail), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        m_tready = 1'b1;
        @(posedge clk); #1;
        n0 = n_out;
        send(3, 0, 2002, 3, tc);
        repeat (8) @(posedge clk); #1;
        chk("t6_beats", 64'(n_out - n0), 64'(3));
        chk("t6_stat_pkt", 64'(stat_pkt), ST ? 64'(1) : 64'(0));
        chk("t6_stat_drop", 64'(stat_drop), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
